// File: rtl/alu_cmp_stage_if.sv
// Beat-level handshake bundle between the ALU adder, the compare stage and the result mux.
// The ALU_CMP_UNSIGNED_EN macro adds the adder carry-out 'c' to the upstream side.
interface alu_cmp_stage_if #(parameter int DW = 32);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] s;
    logic          z;
    logic          v;
    logic          n;
    logic [2:0]    alufun;
    logic          trap_en;
`ifdef ALU_CMP_UNSIGNED_EN
    logic          c;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] cmp_result;
    logic          br_taken;
    logic [DW-1:0] s_out;

`ifdef ALU_CMP_UNSIGNED_EN
    modport master (output in_valid, s, z, v, n, c, alufun, trap_en, out_ready,
                    input  in_ready, out_valid, cmp_result, br_taken, s_out);
    modport slave  (input  in_valid, s, z, v, n, c, alufun, trap_en, out_ready,
                    output in_ready, out_valid, cmp_result, br_taken, s_out);
`else
    modport master (output in_valid, s, z, v, n, alufun, trap_en, out_ready,
                    input  in_ready, out_valid, cmp_result, br_taken, s_out);
    modport slave  (input  in_valid, s, z, v, n, alufun, trap_en, out_ready,
                    output in_ready, out_valid, cmp_result, br_taken, s_out);
`endif
endinterface

// File: rtl/alu_cmp_stage.sv
// Registered set-on-compare stage behind the ALU adder: 2-entry skid buffer plus sticky overflow trap.
// Optional unsigned compare (LTU on code 011) is enabled by defining ALU_CMP_UNSIGNED_EN.
module alu_cmp_stage #(
    parameter int DW        = 32,
    parameter bit TRAP_ON_V = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    alu_cmp_stage_if.slave bus,
    input  logic           flush,
    input  logic           ovf_clr,
    output logic           ovf_flag
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [DW-1:0] s;
        logic          cmp;
`ifdef ALU_CMP_UNSIGNED_EN
        logic          c;
`endif
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   ovf_q, ovf_d;
    logic   cmp_in;
    logic   accept, pop;

    always_comb begin
        cmp_in = 1'b0;
        case (bus.alufun)
            3'b001:  cmp_in = bus.z;
            3'b000:  cmp_in = ~bus.z;
            3'b010:  cmp_in = bus.n ^ bus.v;
            3'b110:  cmp_in = bus.n | bus.z;
            3'b101:  cmp_in = bus.n;
            3'b111:  cmp_in = ~bus.n & ~bus.z;
`ifdef ALU_CMP_UNSIGNED_EN
            3'b011:  cmp_in = ~bus.c;
`endif
            default: cmp_in = 1'b0;
        endcase
    end

    always_comb begin
        in_entry     = '0;
        in_entry.s   = bus.s;
        in_entry.cmp = cmp_in;
`ifdef ALU_CMP_UNSIGNED_EN
        in_entry.c   = bus.c;
`endif
    end

    // in_ready depends only on state and the reset pin, never on out_ready.
    assign bus.in_ready  = reset & (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign accept        = bus.in_valid & bus.in_ready & ~flush;
    assign pop           = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    main_d  = in_entry;
                    state_d = ONE;
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Set beats clear in the same cycle: the trap must not be lost.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)
            ovf_d = 1'b0;
        if (accept && TRAP_ON_V && bus.trap_en && bus.v)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.cmp_result = {{(DW-1){1'b0}}, main_q.cmp};
    assign bus.br_taken   = main_q.cmp;
    assign bus.s_out      = main_q.s;
    assign ovf_flag       = ovf_q;

endmodule

// File: tb/tb_alu_cmp_stage.sv
// Self-checking bench for alu_cmp_stage: compare-code table, backpressure, overflow, flush, reset.
module tb_alu_cmp_stage;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic ovf_clr = 1'b0;
    logic ovf_flag;

    always #5 clk = ~clk;

    alu_cmp_stage_if #(.DW(DW)) bus ();

    alu_cmp_stage #(.DW(DW), .TRAP_ON_V(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .flush    (flush),
        .ovf_clr  (ovf_clr),
        .ovf_flag (ovf_flag)
    );

    typedef struct {
        logic [DW-1:0] s;
        logic          cmp;
    } exp_t;

    typedef struct {
        logic [2:0]    alufun;
        logic [DW-1:0] s;
        logic          z, v, n, c;
        logic          exp_cmp;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] f, input logic [DW-1:0] s, input logic z, input logic v,
                       input logic n, input logic c, input logic e);
        vec_t r;
        r.alufun = f; r.s = s; r.z = z; r.v = v; r.n = n; r.c = c; r.exp_cmp = e;
        vecs.push_back(r);
    endtask

    task automatic set_in(input logic [2:0] f, input logic [DW-1:0] s, input logic z, input logic v,
                          input logic n, input logic c, input logic trap);
        bus.alufun  = f;
        bus.s       = s;
        bus.z       = z;
        bus.v       = v;
        bus.n       = n;
        bus.trap_en = trap;
`ifdef ALU_CMP_UNSIGNED_EN
        bus.c       = c;
`else
        if (c) begin end
`endif
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [2:0] f, input logic [DW-1:0] s, input logic z, input logic v,
                        input logic n, input logic c, input logic trap, input logic e);
        exp_t x;
        bit   done = 0;
        set_in(f, s, z, v, n, c, trap);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready && !flush) begin
                x.s = s; x.cmp = e;
                sbq.push_back(x);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed 0, s=%0h", s);
        end
        bus.in_valid = 1'b0;
        bus.trap_en  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Scoreboard: every pop is compared against the oldest expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.out_valid && bus.out_ready && !flush) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_beat: got s_out=%0h, expected no beat", bus.s_out);
            end else begin
                e = sbq.pop_front();
                check("cmp_result", bus.cmp_result, {{(DW-1){1'b0}}, e.cmp});
                check("br_taken", {{(DW-1){1'b0}}, bus.br_taken}, {{(DW-1){1'b0}}, e.cmp});
                check("s_out", bus.s_out, e.s);
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_in(3'b000, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //         alufun  s             z  v  n  c  exp
        add(3'b010, 32'h0000_0011, 0, 0, 1, 0, 1);
        add(3'b010, 32'h0000_0022, 0, 1, 0, 0, 1);
        add(3'b010, 32'h0000_0033, 0, 1, 1, 0, 0);
        add(3'b010, 32'h0000_0044, 0, 0, 0, 0, 0);
        add(3'b000, 32'h1234_5678, 0, 0, 0, 0, 1);
        add(3'b000, 32'h0000_0000, 1, 0, 0, 0, 0);
        add(3'b110, 32'h0000_0000, 1, 0, 0, 0, 1);
        add(3'b110, 32'h0000_0007, 0, 0, 0, 0, 0);
        add(3'b110, 32'h8000_0000, 0, 0, 1, 0, 1);
        add(3'b101, 32'hFFFF_FFFF, 0, 1, 1, 0, 1);
        add(3'b101, 32'h0000_0009, 0, 0, 0, 0, 0);
        add(3'b111, 32'h0000_0001, 0, 0, 0, 0, 1);
        add(3'b111, 32'h0000_0000, 1, 0, 0, 0, 0);
        add(3'b111, 32'hF000_0000, 0, 0, 1, 0, 0);
        add(3'b001, 32'h0000_0055, 0, 0, 0, 0, 0);
        add(3'b100, 32'h0000_0000, 1, 1, 1, 0, 0);
`ifdef ALU_CMP_UNSIGNED_EN
        add(3'b011, 32'hABCD_0000, 0, 0, 1, 0, 1);
`else
        add(3'b011, 32'hABCD_0000, 0, 0, 1, 0, 0);
`endif
        add(3'b011, 32'hABCD_0001, 1, 1, 1, 1, 0);

        // Reset state while reset is asserted.
        #2;
        check("rst_in_ready", {31'b0, bus.in_ready}, 0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 0);
        check("rst_cmp_result", bus.cmp_result, 0);
        check("rst_br_taken", {31'b0, bus.br_taken}, 0);
        check("rst_s_out", bus.s_out, 0);
        check("rst_ovf_flag", {31'b0, ovf_flag}, 0);
        idle(2);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 1);

        // Single EQ beat with one-cycle latency.
        bus.out_ready = 1'b1;
        send(3'b001, 32'h0, 1, 0, 0, 0, 0, 1);
        check("latency_out_valid", {31'b0, bus.out_valid}, 1);
        idle(2);

        // Table streaming at full rate.
        foreach (vecs[i]) begin
            send(vecs[i].alufun, vecs[i].s, vecs[i].z, vecs[i].v, vecs[i].n, vecs[i].c, 0,
                 vecs[i].exp_cmp);
            check("stream_in_ready", {31'b0, bus.in_ready}, 1);
        end
        idle(3);
        check("no_trap_without_en", {31'b0, ovf_flag}, 0);

        // Backpressure: 5 and 6 fill the buffer, 7 waits.
        bus.out_ready = 1'b0;
        send(3'b101, 32'd5, 0, 0, 1, 0, 0, 1);
        send(3'b101, 32'd6, 0, 0, 1, 0, 0, 1);
        set_in(3'b101, 32'd7, 0, 0, 1, 0, 0);
        bus.in_valid = 1'b1;
        check("bp_in_ready_low", {31'b0, bus.in_ready}, 0);
        check("bp_s_out_hold", bus.s_out, 32'd5);
        idle(1);
        check("bp_s_out_hold2", bus.s_out, 32'd5);
        check("bp_out_valid_hold", {31'b0, bus.out_valid}, 1);
        check("bp_cmp_hold", bus.cmp_result, 32'h1);
        bus.out_ready = 1'b1;
        send(3'b101, 32'd7, 0, 0, 1, 0, 0, 1);
        idle(3);

        // Sticky overflow trap.
        send(3'b010, 32'h7FFF_FFFF, 0, 1, 0, 0, 1, 1);
        check("ovf_set", {31'b0, ovf_flag}, 1);
        ovf_clr = 1'b1;
        send(3'b010, 32'h8000_0000, 0, 1, 1, 0, 1, 0);
        ovf_clr = 1'b0;
        check("ovf_set_beats_clr", {31'b0, ovf_flag}, 1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        check("ovf_clr", {31'b0, ovf_flag}, 0);
        idle(2);

        // Flush while FULL with a beat offered.
        bus.out_ready = 1'b0;
        send(3'b010, 32'h0000_0AAA, 0, 1, 0, 0, 1, 1);
        send(3'b001, 32'h0000_0BBB, 0, 0, 0, 0, 0, 0);
        check("full_in_ready", {31'b0, bus.in_ready}, 0);
        check("full_ovf", {31'b0, ovf_flag}, 1);
        flush = 1'b1;
        set_in(3'b001, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        sbq.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", {31'b0, bus.out_valid}, 0);
        check("flush_in_ready", {31'b0, bus.in_ready}, 1);
        check("flush_keeps_ovf", {31'b0, ovf_flag}, 1);
        bus.out_ready = 1'b1;
        idle(3);
        check("flush_stays_empty", {31'b0, bus.out_valid}, 0);

        // Reset mid-transfer drops the buffered beat.
        bus.out_ready = 1'b0;
        send(3'b111, 32'h0000_0CCC, 0, 0, 0, 0, 0, 1);
        reset = 1'b0;
        #1;
        sbq.delete();
        check("midrst_out_valid", {31'b0, bus.out_valid}, 0);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 0);
        check("midrst_s_out", bus.s_out, 0);
        check("midrst_ovf", {31'b0, ovf_flag}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        send(3'b000, 32'h0000_0DDD, 0, 0, 0, 0, 0, 1);

        for (int k = 0; k < 20 && sbq.size() != 0; k++) idle(1);
        check("drain_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_cmp_stage.md
Name: alu_cmp_stage

Overview:
- Registered compare stage directly downstream of the ALU adder.
- Consumes the adder's sum S and its flags Z/V/N, plus the ALUFun compare code.
- Produces the 32-bit set-on-compare result (0 or 1) and a branch-taken bit.
- Decouples the adder from the result mux with a 2-entry valid/ready skid buffer and captures signed-overflow traps in a sticky register.

Parameters:
- DW, 32, datapath width of S and of cmp_result.
- TRAP_ON_V, 1, when 1 an in-beat with trap_en=1 and v=1 sets ovf_flag.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; asserts immediately, deasserts synchronously to clk.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- s  in  DW  adder sum.
- z  in  1  adder zero flag (S==0).
- v  in  1  adder signed overflow.
- n  in  1  adder sign (S[DW-1]).
- alufun  in  3  ALUFun[3:1] compare code.
- trap_en  in  1  beat is a trapping add/sub.
- flush  in  1  drop all buffered beats.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- cmp_result  out  DW  {DW-1 zeros, cmp_bit}.
- br_taken  out  1  equals cmp_bit.
- s_out  out  DW  registered copy of s.
- ovf_flag  out  1  sticky overflow trap.
- ovf_clr  in  1  clears ovf_flag.

Behaviour:
- Compare decode of alufun:
  - 001 EQ = z
  - 000 NEQ = ~z
  - 010 LT = n^v
  - 110 LEZ = n|z
  - 101 LTZ = n
  - 111 GTZ = ~n&~z
  - all other codes give cmp_bit = 0.
- cmp_bit is computed combinationally at input; only the stored value is registered.
- Buffer: 2 entries, main (drives outputs) and skid. FSM states EMPTY, ONE, FULL.
  - EMPTY: in_valid loads main, go to ONE.
  - ONE with accept and pop in the same cycle: main reloads, stay in ONE.
  - ONE with accept and no pop: load skid, go to FULL.
  - ONE with pop only: go to EMPTY.
  - FULL with pop: skid moves to main, go to ONE.
- in_ready = (state != FULL), registered-equivalent. No combinational path from out_ready to in_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- out_valid = (state != EMPTY).
- Latency: 1 cycle from accept into EMPTY to out_valid. Throughput: 1 beat/cycle while out_ready is high.
- While out_valid=1 and out_ready=0, all outputs are held stable.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- flush (synchronous): state goes to EMPTY next cycle and the in-beat of that cycle is discarded. flush has priority over accept and pop.
- ovf_flag:
  - Set on accept when TRAP_ON_V=1, trap_en=1 and v=1.
  - Cleared by ovf_clr.
  - If set and clear happen in the same cycle, set wins.
  - Flush does not clear ovf_flag.
- Reset values: state EMPTY, out_valid 0, in_ready 1 (0 while reset is asserted), cmp_result 0, br_taken 0, s_out 0, ovf_flag 0.
- Reset mid-transfer discards all buffered beats.

Optional Feature:
- Macro: ALU_CMP_UNSIGNED_EN.
- When defined:
  - Adds port c (in, 1, adder carry-out).
  - Code 011 decodes LTU = ~c.
  - c is stored per entry alongside the beat.
- When undefined:
  - Port c is absent.
  - Code 011 gives cmp_bit = 0.

Test Plan:
- Reset, then single beat alufun=001, z=1, s=0 -> out_valid=1 next cycle, cmp_result=32'h1, br_taken=1, s_out=0.
- Streaming with out_ready held 1:
  - 4 beats LT with (n,v) = (1,0), (0,1), (1,1), (0,0) -> cmp_result 1, 1, 0, 0 on consecutive cycles.
  - in_ready stays 1 throughout.
- Backpressure:
  - out_ready=0 for 3 cycles, in_valid=1 with s=5, then 6, then 7 -> in_ready falls after 2 accepts, s_out holds 5.
  - Then out_ready=1 -> outputs 5, 6, then 7 (7 accepted once in_ready returns).
- Overflow: trap_en=1, v=1 accepted -> ovf_flag=1 next cycle. ovf_clr together with a new v=1 trap beat -> ovf_flag stays 1. ovf_clr alone -> 0.
- Flush in FULL state together with in_valid=1 -> out_valid=0 next cycle, in_ready=1, the flushed input never appears.
- With ALU_CMP_UNSIGNED_EN: alufun=011, c=0 -> cmp_result=1. With c=1 -> 0. With the macro undefined, 011 -> 0.
